exc_merge_stage: RTL
====================

Name: exc_merge_stage

Overview:
- Parametrised successor to the E-stage exception merge.
- Merges an upstream ExcCode with NSRC locally detected exception sources (overflow, address error, RI, etc.) using fixed priority.
- Holds the result in a pipeline register with stall and flush, alongside PC and branch-delay tag, and feeds the next stage / CP0.
- Keeps a saturating count of exceptions latched, for debug.

Parameters:
- NSRC, 4, number of local exception sources in this stage (1..8).
- CODE_W, 5, ExcCode width (the [6:2] field); code 0 means "no exception".
- PC_W, 32, width of the carried PC.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold the register contents.
- flush  in  1  clear the register to a bubble.
- valid_in  in  1  upstream instruction valid.
- pc_in  in  PC_W  upstream PC.
- bd_in  in  1  upstream branch-delay-slot flag.
- ExcCode_in  in  CODE_W  upstream exception code; 0 = none.
- src_valid  in  NSRC  per-source exception request.
- src_code  in  NSRC*CODE_W  per-source code; source i occupies bits [i*CODE_W +: CODE_W].
- src_mask  in  NSRC  per-source enable; 0 disables the source (for example, the overflow enable of add vs addu).
- valid_out  out  1  registered valid.
- pc_out  out  PC_W  registered PC.
- bd_out  out  1  registered BD flag.
- ExcCode_out  out  CODE_W  registered merged code.
- exc_out  out  1  registered, equals valid_out AND (ExcCode_out != 0).
- exc_cnt  out  CNT_W  saturating count of latched exceptions.

Behaviour:
- Reset (async, reset=0): valid_out=0, pc_out=0, bd_out=0, ExcCode_out=0, exc_out=0, exc_cnt=0. Outputs take these values immediately, regardless of clk.
- Merge (combinational, internal):
  - If valid_in=0, the merged code is 0.
  - Else if ExcCode_in != 0, merged = ExcCode_in (earlier stage wins).
  - Else merged = src_code of the lowest index i with src_valid[i] & src_mask[i].
  - Else 0.
  - A source whose code is 0 counts as no request, and the scan continues to the next index.
- Register update on each rising clk with reset=1, in priority order:
  - flush=1: load a bubble. valid_out=0, ExcCode_out=0, exc_out=0, pc_out=0, bd_out=0. Flush overrides stall.
  - Else stall=1: all registers hold.
  - Else: load valid_in, pc_in, bd_in and the merged code; exc_out = valid_in & (merged != 0).
- Latency: one cycle from inputs to outputs; no combinational path from any input to any output.
- exc_cnt increments by 1 on a clock edge that loads a non-zero merged code with valid_in=1, flush=0 and stall=0.
  - Saturates at 2^CNT_W-1; no wrap.
  - It is not cleared by flush, only by reset.
- Simultaneous events:
  - flush and stall together: flush wins, and exc_cnt does not increment.
  - Upstream code and a local source together: the upstream code is latched, and exc_cnt counts once.
- Reset mid-stall: all outputs clear asynchronously. After reset releases, the next unstalled edge loads normally.

Decomposition:
- Shared package (exc_pkg):
  - ExcCode constants: EXC_NONE=0, EXC_INT=0 (handled by CP0, not this block), EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - Default CODE_W=5.
- Sub-module exc_prio_sel: the combinational lowest-index priority selector over NSRC masked sources, outputting the code and a hit flag.
- The top level contains the upstream-wins mux, the pipeline register and the counter.

Test Plan:
- Reset and idle: hold reset=0, then release with valid_in=1 and all sources 0 -> after one clk, valid_out=1, ExcCode_out=0, exc_out=0, exc_cnt=0.
- Local priority: src_valid=4'b1010, codes {src3=5, src1=12}, mask=4'b1111, ExcCode_in=0 -> ExcCode_out=12, exc_out=1, exc_cnt=1. Repeat with mask=4'b1101 -> ExcCode_out=5.
- Upstream wins: ExcCode_in=4 and src0 requesting code 12 -> ExcCode_out=4, exc_cnt increments by exactly 1.
- Stall/flush: latch code 12, then stall=1 for 3 cycles with new inputs -> outputs stay 12, exc_cnt unchanged. Then stall=1 and flush=1 together -> valid_out=0, ExcCode_out=0, exc_out=0.
- Counter saturation: CNT_W=2, present 5 consecutive exceptions -> exc_cnt sequence 1,2,3,3,3.
- Async reset mid-operation: assert reset=0 between clock edges while exc_out=1 -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception-code definitions for the E-stage exception merge logic.
// Codes are the [6:2] ExcCode field of the CP0 Cause register.
package exc_pkg;

  // Default ExcCode field width.
  localparam int EXC_CODE_W = 5;

  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  // EXC_INT shares the value 0 with EXC_NONE. Interrupts are raised by CP0,
  // so this block never produces EXC_INT.
  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_INT  = 5'd0;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;
  localparam exc_code_t EXC_RI   = 5'd10;
  localparam exc_code_t EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_prio_sel.sv
// Fixed-priority selector over NSRC masked local exception sources.
// The lowest index wins. A source counts as a request only when all three
// hold: its valid bit is set, its mask bit is set, and its code is non-zero.
module exc_prio_sel #(
  parameter int NSRC   = 4,
  parameter int CODE_W = 5
) (
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*CODE_W-1:0] src_code,
  input  logic [NSRC-1:0]        src_mask,
  output logic [CODE_W-1:0]      sel_code,
  output logic                   hit
);

  // Scan from the highest index down so that the lowest requesting index is
  // the last one written and therefore wins.
  always_comb begin
    sel_code = '0;
    hit      = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (src_valid[i] && src_mask[i] &&
          (src_code[i*CODE_W +: CODE_W] != '0)) begin
        sel_code = src_code[i*CODE_W +: CODE_W];
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_merge_stage.sv
// E-stage exception merge. The upstream ExcCode takes priority over the
// locally detected sources. The merged result is registered together with the
// PC and the branch-delay flag, and a saturating debug count of latched
// exceptions is kept.
//
// Pipeline control: flush loads a bubble and overrides stall. Stall holds
// every register. With neither asserted, the stage loads its inputs on each
// rising clock edge. All outputs are registered, one cycle after the inputs.
module exc_merge_stage
  import exc_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int CODE_W = EXC_CODE_W,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   valid_in,
  input  logic [PC_W-1:0]        pc_in,
  input  logic                   bd_in,
  input  logic [CODE_W-1:0]      ExcCode_in,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [NSRC*CODE_W-1:0] src_code,
  input  logic [NSRC-1:0]        src_mask,
  output logic                   valid_out,
  output logic [PC_W-1:0]        pc_out,
  output logic                   bd_out,
  output logic [CODE_W-1:0]      ExcCode_out,
  output logic                   exc_out,
  output logic [CNT_W-1:0]       exc_cnt
);

  logic [CODE_W-1:0] local_code;
  logic              local_hit;
  logic [CODE_W-1:0] merged_code;
  logic              merged_exc;
  logic              load_en;

  exc_prio_sel #(
    .NSRC   (NSRC),
    .CODE_W (CODE_W)
  ) u_prio_sel (
    .src_valid (src_valid),
    .src_code  (src_code),
    .src_mask  (src_mask),
    .sel_code  (local_code),
    .hit       (local_hit)
  );

  // Upstream-wins mux. An invalid instruction never carries an exception.
  always_comb begin
    merged_code = CODE_W'(EXC_NONE);
    if (valid_in) begin
      if (ExcCode_in != CODE_W'(EXC_NONE)) begin
        merged_code = ExcCode_in;
      end else if (local_hit) begin
        merged_code = local_code;
      end
    end
  end

  assign merged_exc = valid_in && (merged_code != CODE_W'(EXC_NONE));
  assign load_en    = !flush && !stall;

  // Pipeline register: flush inserts a bubble, stall holds, otherwise load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out   <= 1'b0;
      pc_out      <= '0;
      bd_out      <= 1'b0;
      ExcCode_out <= '0;
      exc_out     <= 1'b0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      pc_out      <= '0;
      bd_out      <= 1'b0;
      ExcCode_out <= '0;
      exc_out     <= 1'b0;
    end else if (!stall) begin
      valid_out   <= valid_in;
      pc_out      <= pc_in;
      bd_out      <= bd_in;
      ExcCode_out <= merged_code;
      exc_out     <= merged_exc;
    end
  end

  // Debug counter: counts exceptions as they are latched and saturates at
  // all-ones. Flush does not clear it; only reset does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_cnt <= '0;
    end else if (load_en && merged_exc && (exc_cnt != '1)) begin
      exc_cnt <= exc_cnt + CNT_W'(1);
    end
  end

endmodule
